// File: rtl/wb_arbiter.sv
// Two-requester round-robin writeback arbiter for a register bank.
// ALU and LSU compete for a single registered write port with one-cycle latency.
//
// last_grant_q | meaning
// 0            | ALU granted last, LSU wins the next tie
// 1            | LSU granted last, ALU wins the next tie (reset value)
module wb_arbiter #(
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [$clog2(NUMREGS)-1:0] alu_waddr_i,
  input  logic [DATAWIDTH-1:0]       alu_wdata_i,
  input  logic                       lsu_valid_i,
  output logic                       lsu_ready_o,
  input  logic [$clog2(NUMREGS)-1:0] lsu_waddr_i,
  input  logic [DATAWIDTH-1:0]       lsu_wdata_i,
  output logic                       we_o,
  output logic [$clog2(NUMREGS)-1:0] waddr_o,
  output logic [DATAWIDTH-1:0]       wdata_o,
  output logic                       last_grant_o
);

  localparam int AW = $clog2(NUMREGS);
  localparam logic [0:0] GRANT_ALU = 1'b0;
  localparam logic [0:0] GRANT_LSU = 1'b1;

  logic                 we_q, we_d;
  logic [AW-1:0]        waddr_q, waddr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic [0:0]           last_grant_q, last_grant_d;
  logic                 alu_grant, lsu_grant;

  always_comb begin
    alu_grant = !rst_i && alu_valid_i && (!lsu_valid_i || (last_grant_q == GRANT_LSU));
    lsu_grant = !rst_i && lsu_valid_i && (!alu_valid_i || (last_grant_q == GRANT_ALU));

    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;

    // Writes to x0 still consume the grant but never assert the bank enable.
    if (alu_grant) begin
      we_d         = |alu_waddr_i;
      waddr_d      = alu_waddr_i;
      wdata_d      = alu_wdata_i;
      last_grant_d = GRANT_ALU;
    end else if (lsu_grant) begin
      we_d         = |lsu_waddr_i;
      waddr_d      = lsu_waddr_i;
      wdata_d      = lsu_wdata_i;
      last_grant_d = GRANT_LSU;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      last_grant_q <= GRANT_LSU;
    end else begin
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign alu_ready_o  = alu_grant;
  assign lsu_ready_o  = lsu_grant;
  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign last_grant_o = last_grant_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUMREGS, default 32, giving the number of architectural registers in the register bank.
REQ-002 The block SHALL have parameter DATAWIDTH, default 32, giving the register data width.
REQ-003 clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset, sampled on the rising edge of clk_i.
REQ-005 alu_valid_i  input  1  ALU writeback request (requester 0).
REQ-006 alu_ready_o  output  1  ALU request accepted this cycle.
REQ-007 alu_waddr_i  input  $clog2(NUMREGS)  ALU destination register.
REQ-008 alu_wdata_i  input  DATAWIDTH  ALU result.
REQ-009 lsu_valid_i  input  1  load/store unit writeback request (requester 1).
REQ-010 lsu_ready_o  output  1  LSU request accepted this cycle.
REQ-011 lsu_waddr_i  input  $clog2(NUMREGS)  LSU destination register.
REQ-012 lsu_wdata_i  input  DATAWIDTH  load data.
REQ-013 we_o  output  1  register bank write enable.
REQ-014 waddr_o  output  $clog2(NUMREGS)  register bank write address.
REQ-015 wdata_o  output  DATAWIDTH  register bank write data.
REQ-016 last_grant_o  output  1  round-robin state: 0 means ALU granted last, 1 means LSU granted last.

Function
REQ-017 A transfer SHALL occur in a cycle where a requester's valid and ready are both high.
- ready_o is combinational from valid_i and the round-robin state.
- ready_o is never gated by waddr or wdata.
REQ-018 At most one of alu_ready_o and lsu_ready_o SHALL be high in any cycle.
- A requester's ready_o is never high while its valid_i is low.
REQ-019 If exactly one requester is valid, that requester SHALL be granted, regardless of the round-robin state.
REQ-020 If both requesters are valid, the requester not recorded in last_grant_o SHALL be granted.
- last_grant_o=0: LSU wins.
- last_grant_o=1: ALU wins.
REQ-021 On every grant, last_grant_o SHALL update at the next edge to the granted requester.
- When no requester is valid, last_grant_o holds its value.
REQ-022 A requester that is valid but not ready SHALL hold valid, waddr and wdata stable until accepted.
- Violation is a protocol error; it is flagged by a bench assertion, not handled by the block.
REQ-023 The write port SHALL be registered with a latency of exactly one cycle.
- A transfer in cycle N drives waddr_o/wdata_o with the granted address and data in cycle N+1.
- we_o=1 in cycle N+1 unless REQ-024 applies.
REQ-024 A transfer with waddr equal to 0 SHALL be accepted (ready high) and counts as a grant for round-robin.
- It produces we_o=0 in cycle N+1 (writes to x0 are discarded).
REQ-025 In a cycle following no transfer, we_o SHALL be 0.
- waddr_o/wdata_o hold their previous values.
REQ-026 Back-to-back transfers SHALL be supported every cycle with no bubble.
- Sustained throughput is one write per cycle.
REQ-027 Consecutive transfers to the same register SHALL reach the write port in grant order.
- The bank is left holding the later value.

Reset
REQ-028 While rst_i is high, alu_ready_o and lsu_ready_o SHALL be 0.
- No transfer occurs in a reset cycle, even if valid_i is high.
REQ-029 In the cycle after a reset edge, outputs SHALL be we_o=0, waddr_o=0, wdata_o=0 and last_grant_o=1.
- last_grant_o=1 gives the ALU first priority on a tie.
REQ-030 Reset asserted in the cycle after a transfer SHALL clear we_o at that edge.
- The pending write is lost and never reaches the bank.

Verification
REQ-031 Single ALU write: after reset, alu_valid_i=1, addr=5, data=0xDEADBEEF, lsu idle.
- Response: alu_ready_o=1 the same cycle.
- Next cycle: we_o=1, waddr_o=5, wdata_o=0xDEADBEEF; then we_o=0.
REQ-032 Tie after reset: ALU (addr 3, 0x11) and LSU (addr 4, 0x22) both valid and held.
- Cycle 1: ALU granted; lsu_ready_o=0.
- Cycle 2: LSU granted.
- Write port shows 3/0x11, then 4/0x22, on consecutive cycles.
REQ-033 Sustained contention: both requesters valid for 8 cycles with changing payloads.
- Grants alternate ALU, LSU, ALU, and so on.
- we_o is high for 8 consecutive cycles; no payload is dropped or duplicated.
REQ-034 x0 write: LSU valid with addr=0, data=0xFFFFFFFF.
- Response: lsu_ready_o=1, we_o=0 next cycle, last_grant_o becomes 1.
- An immediately following ALU/LSU tie grants the ALU.
REQ-035 Reset mid-operation: ALU transfer in cycle N, rst_i=1 in cycle N+1.
- Response: we_o=0 after the reset edge; both readies are 0 during reset.
- After reset, last_grant_o=1 and all outputs are 0.
